wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter CSR_TOHOST, default 12'h51E, the CSR address of the tohost register.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013, the bubble encoding that is excluded from the retire count.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset; synchronous and active-high.
REQ-005 SHALL have port wb_pc4, input, 32: PC+4 of the WB instruction.
REQ-006 SHALL have port wb_alu, input, 32: ALU result, or CSR write data, of the WB instruction.
REQ-007 SHALL have port wb_inst, input, 32: WB instruction.
REQ-008 SHALL have port wb_addr, input, 32: memory address of the WB load.
REQ-009 SHALL have port mem_dmem_dout, input, 32: sync-read DMem word, valid in the WB cycle.
REQ-010 SHALL have port mem_io_dout, input, 32: IO read word, valid in the WB cycle.
REQ-011 SHALL have port wb_stall, input, 1: pipeline hold; when high the WB instruction does not commit this cycle.
REQ-012 SHALL have port counter_clr, input, 1: clear request for the cycle and instret counters.
REQ-013 SHALL have port wb_wdata, output, 32: register-file write data, also the forwarding source.
REQ-014 SHALL have port wb_rd, output, 5: destination register, equal to wb_inst[11:7].
REQ-015 SHALL have port wb_we, output, 1: register-file write enable.
REQ-016 SHALL have port csr_tohost, output, 32: tohost register value.
REQ-017 SHALL have port cycle_cnt, output, 32: cycle counter.
REQ-018 SHALL have port instret_cnt, output, 32: retired-instruction counter.

Function
REQ-019 wb_wdata, wb_rd and wb_we SHALL be combinational from the current inputs and state (zero added latency).
REQ-020 Loads (opcode 0000011) SHALL take data from mem_io_dout when wb_addr[31:28]==4'b1000, and from mem_dmem_dout otherwise.
REQ-021 Lane selection SHALL be: LB/LBU use byte wb_addr[1:0]; LH/LHU use halfword wb_addr[1] and ignore addr[0]; LW uses the full word and ignores addr[1:0].
REQ-022 Load extension SHALL be: LB/LH sign-extend; LBU/LHU zero-extend; an undefined load funct3 returns 0.
REQ-023 wb_wdata for JAL/JALR SHALL be wb_pc4.
REQ-024 wb_wdata for LUI/AUIPC/OP/OP-IMM SHALL be wb_alu.
REQ-025 wb_wdata for CSRRW/CSRRWI to CSR_TOHOST SHALL be the pre-write csr_tohost.
REQ-026 wb_wdata for any other opcode SHALL be 0.
REQ-027 wb_we SHALL be 1 iff the opcode writes rd (load, JAL, JALR, LUI, AUIPC, OP, OP-IMM, CSRRW/CSRRWI), rd!=0, and wb_stall=0.
REQ-028 Stores, branches and unknown opcodes SHALL never assert wb_we.
REQ-029 csr_tohost SHALL load wb_alu at the clock edge when the opcode is SYSTEM, funct3 is 001 or 101, inst[31:20]==CSR_TOHOST, and wb_stall=0; it SHALL otherwise hold.
REQ-030 A CSR access to any other address SHALL have no side effect and SHALL return rd data 0.
REQ-031 cycle_cnt SHALL increment by 1 every cycle, including stalled cycles, wrapping 32'hFFFF_FFFF to 0.
REQ-032 instret_cnt SHALL increment iff wb_stall=0 and wb_inst!=NOP_INST, with the same wrap.
REQ-033 When counter_clr=1, both counters SHALL be 0 on the next cycle; clear wins over a simultaneous increment.
REQ-034 counter_clr SHALL not affect csr_tohost.

Reset
REQ-035 When rst=1 at a rising edge, csr_tohost, cycle_cnt and instret_cnt SHALL all be 0 on the next cycle; reset takes priority over counter_clr, CSR writes and increments.
REQ-036 During reset, wb_we SHALL be forced to 0 regardless of wb_inst, so a reset mid-operation never writes the register file.

Structure
REQ-037 Opcode, funct3 and CSR-address constants and NOP_INST SHALL live in the shared RISC-V defines header used by all stages.
REQ-038 Load lane selection and extension SHALL be one combinational sub-module, load_align; decode, muxing, CSR and counters SHALL stay in wb_stage.

Verification
REQ-039 Bench SHALL apply LB, addr 0x0000_1003, dmem_dout 0x80FF_1234 -> wdata 0xFFFF_FF80; then LBU, same inputs -> wdata 0x0000_0080.
REQ-040 Bench SHALL apply LH, addr 0x8000_0012, io_dout 0xBEEF_0000 -> wdata 0xFFFF_BEEF, sourced from io and not dmem.
REQ-041 Bench SHALL apply CSRRW 0x51E, wb_alu 0x0000_0001 with tohost 0 -> wdata 0, and tohost 1 next cycle; the same instruction with wb_stall=1 -> tohost unchanged, we 0.
REQ-042 Bench SHALL apply JAL with rd=x0 -> we 0; the same instruction with rd=x1, pc4 0x0000_2008 -> we 1, wdata 0x0000_2008.
REQ-043 Bench SHALL run 10 cycles of 4 real instructions, 3 NOPs and 3 stalls -> cycle_cnt 10, instret_cnt 4; then counter_clr together with a retiring instruction -> both counters 0.
REQ-044 Bench SHALL preload cycle_cnt to 0xFFFF_FFFF -> 0 next cycle; and assert rst during a CSR write -> tohost 0 and we 0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// wb_stage_pkg: shared RISC-V opcode, funct3 and CSR constants for the stages.
// Rev 1.0
// ============================================================================
package wb_stage_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_LB     = 3'b000;
  localparam logic [2:0] F3_LH     = 3'b001;
  localparam logic [2:0] F3_LW     = 3'b010;
  localparam logic [2:0] F3_LBU    = 3'b100;
  localparam logic [2:0] F3_LHU    = 3'b101;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRWI = 3'b101;

  localparam logic [11:0] CSR_TOHOST_ADDR = 12'h51E;
  localparam logic [31:0] NOP_INST_ENC    = 32'h0000_0013;
  localparam logic [3:0]  IO_REGION       = 4'b1000;

  function automatic logic is_csr_write(input logic [6:0] opcode, input logic [2:0] funct3);
    return (opcode == OPC_SYSTEM) && ((funct3 == F3_CSRRW) || (funct3 == F3_CSRRWI));
  endfunction

  // Stores, branches, other SYSTEM forms and unknown opcodes never write rd.
  function automatic logic writes_rd(input logic [6:0] opcode, input logic [2:0] funct3);
    case (opcode)
      OPC_LOAD, OPC_JAL, OPC_JALR, OPC_LUI,
      OPC_AUIPC, OPC_OP, OPC_OP_IMM: return 1'b1;
      OPC_SYSTEM:                    return is_csr_write(opcode, funct3);
      default:                       return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_stage_load_align.sv
`default_nettype none
// ============================================================================
// load_align: byte/halfword lane selection and sign/zero extension for loads.
// Rev 1.0
// ============================================================================
module load_align
  import wb_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'b0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'b0, half_sel};
      F3_LW:   data = word;
      default: data = 32'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// wb_stage: writeback mux, register-file write control, tohost CSR and counters.
// Rev 1.0
// ============================================================================
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [11:0] CSR_TOHOST = CSR_TOHOST_ADDR,
  parameter logic [31:0] NOP_INST   = NOP_INST_ENC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_pc4,
  input  logic [31:0] wb_alu,
  input  logic [31:0] wb_inst,
  input  logic [31:0] wb_addr,
  input  logic [31:0] mem_dmem_dout,
  input  logic [31:0] mem_io_dout,
  input  logic        wb_stall,
  input  logic        counter_clr,
  output logic [31:0] wb_wdata,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic [31:0] csr_tohost,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        tohost_hit;
  logic [31:0] load_word;
  logic [31:0] load_data;
  logic        unused_bits;

  assign opcode      = wb_inst[6:0];
  assign funct3      = wb_inst[14:12];
  assign wb_rd       = wb_inst[11:7];
  assign tohost_hit  = is_csr_write(opcode, funct3) && (wb_inst[31:20] == CSR_TOHOST);
  assign load_word   = (wb_addr[31:28] == IO_REGION) ? mem_io_dout : mem_dmem_dout;
  assign unused_bits = &{1'b0, wb_addr[27:2], wb_inst[19:15]};

  load_align u_load_align (
    .word    (load_word),
    .addr_lo (wb_addr[1:0]),
    .funct3  (funct3),
    .data    (load_data)
  );

  always_comb begin
    wb_wdata = 32'b0;
    case (opcode)
      OPC_LOAD:                             wb_wdata = load_data;
      OPC_JAL, OPC_JALR:                    wb_wdata = wb_pc4;
      OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM: wb_wdata = wb_alu;
      // CSR swap returns the value held before this instruction's write.
      OPC_SYSTEM: if (tohost_hit)           wb_wdata = csr_tohost;
      default: ;
    endcase
  end

  assign wb_we = writes_rd(opcode, funct3) && (wb_rd != 5'd0) && !wb_stall && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      csr_tohost  <= 32'b0;
      cycle_cnt   <= 32'b0;
      instret_cnt <= 32'b0;
    end else begin
      if (tohost_hit && !wb_stall) csr_tohost <= wb_alu;
      if (counter_clr) begin
        cycle_cnt   <= 32'b0;
        instret_cnt <= 32'b0;
      end else begin
        cycle_cnt <= cycle_cnt + 32'd1;
        if (!wb_stall && (wb_inst != NOP_INST)) instret_cnt <= instret_cnt + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// tb_wb_stage: directed and randomized checks of wb_stage against a spec model.
// Rev 1.0
// ============================================================================
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_pc4, wb_alu, wb_inst, wb_addr, dmem, io;
  logic        stall, clr;
  logic [31:0] wb_wdata;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] csr_tohost, cycle_cnt, instret_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_tohost, m_cycle, m_instret;

  wb_stage dut (
    .clk           (clk),
    .rst           (rst),
    .wb_pc4        (wb_pc4),
    .wb_alu        (wb_alu),
    .wb_inst       (wb_inst),
    .wb_addr       (wb_addr),
    .mem_dmem_dout (dmem),
    .mem_io_dout   (io),
    .wb_stall      (stall),
    .counter_clr   (clr),
    .wb_wdata      (wb_wdata),
    .wb_rd         (wb_rd),
    .wb_we         (wb_we),
    .csr_tohost    (csr_tohost),
    .cycle_cnt     (cycle_cnt),
    .instret_cnt   (instret_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [11:0] imm, input logic [4:0] rs1,
                                     input logic [2:0] f3, input logic [4:0] rd,
                                     input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic is_tohost_wr(input logic [31:0] inst);
    return inst[6:0] == 7'h73 && (inst[14:12] == 3'd1 || inst[14:12] == 3'd5)
           && inst[31:20] == 12'h51E;
  endfunction

  // Reference writeback value computed with shifts and casts from the ISA rules.
  function automatic logic [31:0] exp_wdata(input logic [31:0] inst, pc4, alu, addr,
                                            input logic [31:0] d, i, tohost);
    logic [31:0] src, sh;
    logic [7:0]  b;
    logic [15:0] h;
    src = (addr[31:28] == 4'h8) ? i : d;
    sh  = src >> (8 * addr[1:0]);
    b   = sh[7:0];
    sh  = src >> (16 * addr[1]);
    h   = sh[15:0];
    case (inst[6:0])
      7'h03: case (inst[14:12])
               3'd0: return 32'($signed(b));
               3'd4: return {24'b0, b};
               3'd1: return 32'($signed(h));
               3'd5: return {16'b0, h};
               3'd2: return src;
               default: return 32'b0;
             endcase
      7'h6F, 7'h67: return pc4;
      7'h37, 7'h17, 7'h33, 7'h13: return alu;
      7'h73: return is_tohost_wr(inst) ? tohost : 32'b0;
      default: return 32'b0;
    endcase
  endfunction

  function automatic logic exp_we(input logic [31:0] inst, input logic st, input logic r);
    logic wr;
    case (inst[6:0])
      7'h03, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h33, 7'h13: wr = 1'b1;
      7'h73: wr = (inst[14:12] == 3'd1 || inst[14:12] == 3'd5);
      default: wr = 1'b0;
    endcase
    return wr && inst[11:7] != 5'd0 && !st && !r;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] opcs [0:10];
    logic [31:0] r;
    logic [2:0] sys_f3 [0:3];
    opcs = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h33, 7'h13, 7'h73, 7'h7F};
    sys_f3 = '{3'd1, 3'd5, 3'd2, 3'd0};
    r = $urandom;
    if ($urandom_range(0, 7) == 0) return 32'h0000_0013;
    r[6:0] = opcs[$urandom_range(0, 10)];
    if (r[6:0] == 7'h73) begin
      r[14:12] = sys_f3[$urandom_range(0, 3)];
      if ($urandom_range(0, 2) != 0) r[31:20] = 12'h51E;
    end
    if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  // Advance one clock: update the model from the inputs present at the edge.
  task automatic tick();
    if (rst) begin
      m_tohost = 0; m_cycle = 0; m_instret = 0;
    end else begin
      if (!stall && is_tohost_wr(wb_inst)) m_tohost = wb_alu;
      if (clr) begin
        m_cycle = 0; m_instret = 0;
      end else begin
        m_cycle = m_cycle + 1;
        if (!stall && wb_inst != 32'h13) m_instret = m_instret + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; stall = 0; clr = 0;
    wb_pc4 = 0; wb_alu = 0; wb_addr = 0; dmem = 0; io = 0;
    wb_inst = 32'h0000_0013;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    wb_inst = mk(12'h0, 5'd0, 3'd0, 5'd1, 7'h6F);
    wb_pc4 = 32'h44;
    tick();
    tick();
    #1;
    checks++;
    if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", wb_we); end
    checks++;
    if ({csr_tohost, cycle_cnt, instret_cnt} !== 96'b0) begin
      errors++;
      $display("FAIL reset_regs: got %h %h %h expected 0 0 0", csr_tohost, cycle_cnt, instret_cnt);
    end
    idle();
  endtask

  task automatic test_loads();
    idle();
    wb_inst = mk(12'h0, 5'd0, 3'd0, 5'd5, 7'h03);
    wb_addr = 32'h0000_1003; dmem = 32'h80FF_1234; io = 32'h0;
    #1;
    checks++;
    if (wb_wdata !== 32'hFFFF_FF80 || wb_we !== 1'b1 || wb_rd !== 5'd5) begin
      errors++; $display("FAIL lb: got %h we %b rd %0d expected ffffff80 1 5", wb_wdata, wb_we, wb_rd);
    end
    wb_inst = mk(12'h0, 5'd0, 3'd4, 5'd5, 7'h03);
    #1;
    checks++;
    if (wb_wdata !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu: got %h expected 00000080", wb_wdata);
    end
    wb_inst = mk(12'h0, 5'd0, 3'd1, 5'd5, 7'h03);
    wb_addr = 32'h8000_0012; io = 32'hBEEF_0000; dmem = 32'h1234_5678;
    #1;
    checks++;
    if (wb_wdata !== 32'hFFFF_BEEF) begin
      errors++; $display("FAIL lh_io: got %h expected ffffbeef", wb_wdata);
    end
    for (int k = 0; k < 40; k++) begin
      logic [2:0] f3s [0:7];
      logic [31:0] e;
      f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
      wb_inst = mk(12'($urandom), 5'($urandom), f3s[k % 8], 5'($urandom_range(1, 31)), 7'h03);
      wb_addr = $urandom;
      if (k % 2 == 0) wb_addr[31:28] = 4'h8;
      dmem = $urandom; io = $urandom;
      #1;
      e = exp_wdata(wb_inst, wb_pc4, wb_alu, wb_addr, dmem, io, m_tohost);
      checks++;
      if (wb_wdata !== e) begin
        errors++; $display("FAIL load_rand: inst %h addr %h got %h expected %h", wb_inst, wb_addr, wb_wdata, e);
      end
    end
    idle();
  endtask

  task automatic test_csr();
    idle();
    wb_inst = mk(12'h51E, 5'd1, 3'd1, 5'd5, 7'h73);
    wb_alu = 32'h0000_0001;
    #1;
    checks++;
    if (wb_wdata !== 32'h0 || wb_we !== 1'b1) begin
      errors++; $display("FAIL csr_rd: got %h we %b expected 00000000 1", wb_wdata, wb_we);
    end
    tick();
    checks++;
    if (csr_tohost !== 32'h1) begin
      errors++; $display("FAIL csr_write: got %h expected 00000001", csr_tohost);
    end
    stall = 1; wb_alu = 32'h0000_0005;
    #1;
    checks++;
    if (wb_we !== 1'b0 || wb_wdata !== 32'h1) begin
      errors++; $display("FAIL csr_stall_comb: got we %b wdata %h expected 0 00000001", wb_we, wb_wdata);
    end
    tick();
    checks++;
    if (csr_tohost !== 32'h1) begin
      errors++; $display("FAIL csr_stall_hold: got %h expected 00000001", csr_tohost);
    end
    stall = 0;
    wb_inst = mk(12'h340, 5'd1, 3'd1, 5'd6, 7'h73);
    wb_alu = 32'hAAAA_5555;
    #1;
    checks++;
    if (wb_wdata !== 32'h0) begin
      errors++; $display("FAIL csr_other_rd: got %h expected 00000000", wb_wdata);
    end
    tick();
    checks++;
    if (csr_tohost !== 32'h1) begin
      errors++; $display("FAIL csr_other_noeffect: got %h expected 00000001", csr_tohost);
    end
    idle();
  endtask

  task automatic test_jal();
    idle();
    wb_inst = mk(12'h0, 5'd0, 3'd0, 5'd0, 7'h6F);
    wb_pc4 = 32'h0000_2008;
    #1;
    checks++;
    if (wb_we !== 1'b0) begin errors++; $display("FAIL jal_x0: got we %b expected 0", wb_we); end
    wb_inst = mk(12'h0, 5'd0, 3'd0, 5'd1, 7'h6F);
    #1;
    checks++;
    if (wb_we !== 1'b1 || wb_wdata !== 32'h0000_2008) begin
      errors++; $display("FAIL jal_x1: got we %b wdata %h expected 1 00002008", wb_we, wb_wdata);
    end
    wb_inst = mk(12'h0, 5'd1, 3'd2, 5'd3, 7'h23);
    #1;
    checks++;
    if (wb_we !== 1'b0) begin errors++; $display("FAIL store_we: got %b expected 0", wb_we); end
    idle();
  endtask

  task automatic test_counters();
    logic [31:0] pattern [0:9];
    logic        stalls  [0:9];
    idle();
    clr = 1;
    tick();
    clr = 0;
    pattern = '{32'h00100093, 32'h13, 32'h00100093, 32'h00100093, 32'h13,
                32'h00100093, 32'h00100093, 32'h00100093, 32'h13, 32'h00100093};
    stalls  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 10; k++) begin
      wb_inst = pattern[k];
      stall = stalls[k];
      tick();
    end
    checks++;
    if (cycle_cnt !== 32'd10 || instret_cnt !== 32'd4) begin
      errors++; $display("FAIL counters_10: got cycle %0d instret %0d expected 10 4", cycle_cnt, instret_cnt);
    end
    stall = 0; wb_inst = 32'h00100093; clr = 1;
    tick();
    checks++;
    if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
      errors++; $display("FAIL counter_clr: got cycle %0d instret %0d expected 0 0", cycle_cnt, instret_cnt);
    end
    idle();
  endtask

  task automatic test_wrap();
    idle();
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    m_cycle = 32'hFFFF_FFFF;
    checks++;
    if (cycle_cnt !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wrap_preload: got %h expected ffffffff", cycle_cnt);
    end
    tick();
    checks++;
    if (cycle_cnt !== 32'h0) begin
      errors++; $display("FAIL cycle_wrap: got %h expected 00000000", cycle_cnt);
    end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] e;
    logic        ew;
    for (int k = 0; k < 300; k++) begin
      wb_inst = rand_inst();
      wb_pc4 = $urandom; wb_alu = $urandom; dmem = $urandom; io = $urandom;
      wb_addr = $urandom;
      if ($urandom_range(0, 1) == 1) wb_addr[31:28] = 4'h8;
      stall = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 31) == 0);
      #1;
      e  = exp_wdata(wb_inst, wb_pc4, wb_alu, wb_addr, dmem, io, m_tohost);
      ew = exp_we(wb_inst, stall, rst);
      checks++;
      if (wb_wdata !== e || wb_we !== ew || wb_rd !== wb_inst[11:7]) begin
        errors++;
        $display("FAIL rand_comb: inst %h got wdata %h we %b rd %0d expected %h %b %0d",
                 wb_inst, wb_wdata, wb_we, wb_rd, e, ew, wb_inst[11:7]);
      end
      tick();
      checks++;
      if (csr_tohost !== m_tohost || cycle_cnt !== m_cycle || instret_cnt !== m_instret) begin
        errors++;
        $display("FAIL rand_regs: got %h %h %h expected %h %h %h",
                 csr_tohost, cycle_cnt, instret_cnt, m_tohost, m_cycle, m_instret);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_csr();
    idle();
    wb_inst = mk(12'h51E, 5'd2, 3'd1, 5'd7, 7'h73);
    wb_alu = 32'h0000_BEEF;
    tick();
    checks++;
    if (csr_tohost !== 32'h0000_BEEF) begin
      errors++; $display("FAIL pre_reset_write: got %h expected 0000beef", csr_tohost);
    end
    wb_alu = 32'h0000_DEAD;
    rst = 1;
    #1;
    checks++;
    if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_csr_we: got %b expected 0", wb_we); end
    tick();
    checks++;
    if (csr_tohost !== 32'h0 || cycle_cnt !== 32'h0 || instret_cnt !== 32'h0) begin
      errors++; $display("FAIL reset_csr_regs: got %h %h %h expected 0 0 0", csr_tohost, cycle_cnt, instret_cnt);
    end
    idle();
  endtask

  initial begin
    m_tohost = 0; m_cycle = 0; m_instret = 0;
    idle();
    test_reset();
    test_loads();
    test_csr();
    test_jal();
    test_counters();
    test_wrap();
    test_random();
    test_reset_mid_csr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
